mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, 4, consecutive LSU grants allowed while ifetch waits.
REQ-002 Parameter: IO_ADDR0, 32'h30000, first IO-buffered store address.
REQ-003 Parameter: IO_ADDR1, 32'h30004, second IO-buffered store address.
REQ-004 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- rdy  in  1  global enable; low freezes all state.
- clear  in  1  pipeline flush.
- io_buffer_full  in  1  UART buffer full.
- if_req  in  1  fetch request, level.
- if_addr  in  32  fetch byte address.
- if_done  out  1  one-cycle fetch completion.
- if_rdata  out  32  fetched word.
- ls_req  in  1  load/store request, level.
- ls_we  in  1  0 = load, 1 = store.
- ls_size  in  2  0 = byte, 1 = half, 2 = word.
- ls_signed  in  1  load sign-extend enable.
- ls_addr  in  32  byte address.
- ls_wdata  in  32  store data.
- ls_done  out  1  one-cycle completion.
- ls_rdata  out  32  extended load data.
- mem_wr  out  1  RAM write enable.
- mem_a  out  32  RAM address.
- mem_dout  out  8  RAM write byte.
- mem_din  in  8  RAM read byte, one-cycle latency.

Function
REQ-005 The FSM states SHALL be IDLE, RD, RD_TAIL, WR, DONE.
REQ-006 In IDLE, if exactly one request is high, that requester SHALL be granted; if both are high, LSU wins unless starve_cnt == STARVE_MAX, in which case ifetch wins.
REQ-007 On grant, the FSM SHALL latch owner, address, size (ifetch = word), we, signed, and wdata; byte count N = 1/2/4; reads go to RD, writes go to WR.
REQ-008 In RD cycle k (k = 1..N), mem_a SHALL equal base+k-1 and mem_wr SHALL be 0; the byte returned for cycle k is captured at the end of cycle k+1 into lane k-1; after cycle N, the FSM enters RD_TAIL for one cycle to capture the final byte.
REQ-009 In WR cycle k, mem_wr SHALL be 1, mem_a SHALL be base+k-1, and mem_dout SHALL be wdata[8k-1:8k-8]; after N cycles, the FSM enters DONE.
REQ-010 IO hold: in WR, if (io_buffer_full or io_full_q) and the current byte address is IO_ADDR0 or IO_ADDR1, then mem_wr SHALL be 0 and the byte counter SHALL hold; io_full_q is io_buffer_full registered.
REQ-011 In DONE, exactly one of if_done or ls_done SHALL pulse for one cycle with rdata valid, after which the FSM returns to IDLE.
REQ-012 Latency, measured from the IDLE grant cycle (0): word read done in cycle 6, half in 4, byte in 3; write done in cycle N+1 when no IO hold.
REQ-013 Load result: size byte/half SHALL be zero-extended, or sign-extended from bit 7/15 when ls_signed; if_rdata SHALL be the raw 4-byte little-endian word.
REQ-014 if_rdata and ls_rdata SHALL hold their value until the next completion of the same owner.
REQ-015 Requesters SHALL keep req and operands stable until done, and SHALL drop req the cycle after done; the arbiter SHALL sample requests only in IDLE.
REQ-016 starve_cnt (3 bits, saturating at STARVE_MAX) SHALL increment on an LSU grant while if_req is high, and SHALL clear on an ifetch grant.
REQ-017 clear SHALL abort RD, RD_TAIL, and read-owned DONE to IDLE with no done pulse, and SHALL clear starve_cnt; an in-flight WR SHALL complete normally, including ls_done.
REQ-018 If clear coincides with an IDLE request, no grant SHALL occur that cycle.
REQ-019 rdy low SHALL freeze FSM, counters, and captured data; mem_wr SHALL be forced to 0 while rdy is low.
REQ-020 Outside RD and WR, mem_a SHALL be 0 and mem_wr SHALL be 0.
REQ-021 Byte address arithmetic SHALL wrap modulo 2^32.

Reset
REQ-022 When rst is low at a rising edge: state = IDLE, starve_cnt = 0, io_full_q = 0, all rdata = 0, if_done = 0, ls_done = 0, mem_wr = 0, mem_a = 0, mem_dout = 0.
REQ-023 Reset mid-transaction SHALL abandon the transaction with no done pulse.
REQ-024 Reset SHALL take priority over rdy and clear.

Structure
REQ-025 The shared define header (info.v) SHALL hold the size encodings, FSM state codes, and IO addresses.
REQ-026 One sub-module, mem_arb_extend, SHALL perform the combinational byte/half sign/zero extension.

Verification
REQ-027 Reset, then ifetch word at 0x100 with RAM bytes 11,22,33,44: if_done in cycle 6, if_rdata = 0x44332211.
REQ-028 Signed byte load of 0x80 at 0x200: ls_rdata = 0xFFFFFF80; the same load unsigned returns 0x00000080.
REQ-029 Both requests held continuously: grant order L,L,L,L,F,L...; never more than 4 LSU grants between fetches.
REQ-030 Store byte 0x41 to 0x30000 with io_buffer_full high for 5 cycles: mem_wr stays 0 until one cycle after full drops, then one write with mem_dout = 0x41 and ls_done.
REQ-031 clear during word-read cycle 3: no done pulse, FSM in IDLE next cycle; clear during store cycle 2: store finishes all 4 bytes and ls_done pulses.
REQ-032 rdy low for 3 cycles mid-read: result and latency are shifted by exactly 3 cycles; rst low mid-write: all outputs return to 0 the next cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: size encodings, FSM state
// codes, requester identity, IO-buffered store addresses and a byte-count
// helper.
package mem_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Default UART-style addresses whose stores stall while the IO buffer is full
  localparam logic [31:0] IO_ADDR0_DEFAULT = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR1_DEFAULT = 32'h0003_0004;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_TAIL = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Number of byte beats for an access size; anything not byte/half is a word
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_BYTE: byte_count = 3'd1;
      SZ_HALF: byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_extend.sv
// Combinational load-result formatting: byte/half are zero- or
// sign-extended to 32 bits, words pass through unchanged.
module mem_arb_extend
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        sign_en,
  output logic [31:0] result
);

  // Pick the low lanes and replicate the sign bit only when requested
  always_comb begin
    result = word;
    case (size)
      SZ_BYTE: result = {{24{sign_en & word[7]}}, word[7:0]};
      SZ_HALF: result = {{16{sign_en & word[15]}}, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch and load/store unit) in front
// of a byte-wide RAM with one-cycle read latency. Multi-byte accesses are
// serialised one byte per cycle; stores to IO addresses stall while the
// IO buffer reports full. LSU normally wins, but ifetch is forced through
// after STARVE_MAX consecutive LSU grants made while it was waiting.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [31:0] IO_ADDR0   = IO_ADDR0_DEFAULT,
  parameter logic [31:0] IO_ADDR1   = IO_ADDR1_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic        ls_signed,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t      state_reg, state_next;
  owner_t      owner_reg, owner_next;
  logic [31:0] addr_reg, addr_next;
  logic [1:0]  size_reg, size_next;
  logic        we_reg, we_next;
  logic        sign_reg, sign_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [2:0]  starve_reg, starve_next;
  logic        io_full_reg;
  logic        pend_reg, pend_next;
  logic [1:0]  pend_lane_reg, pend_lane_next;
  logic [31:0] if_rdata_reg, if_rdata_next;
  logic [31:0] ls_rdata_reg, ls_rdata_next;

  logic [7:0]  lane_reg [4];
  logic [31:0] word;
  logic [31:0] ls_ext;
  logic [31:0] cur_addr;
  logic [2:0]  nbytes;
  logic        last_beat;
  logic        io_hold;
  logic        grant_ls;

  assign cur_addr  = addr_reg + 32'(cnt_reg);
  assign nbytes    = byte_count(size_reg);
  assign last_beat = (cnt_reg == nbytes - 3'd1);
  assign io_hold   = (io_buffer_full | io_full_reg) &&
                     ((cur_addr == IO_ADDR0) || (cur_addr == IO_ADDR1));
  assign grant_ls  = ls_req && !(if_req && (starve_reg == STARVE_LIM));

  // Read bytes land one cycle after their address; each lane captures the
  // byte owed to it. Capture also happens on a frozen (rdy low) cycle so a
  // byte already on its way from the RAM is not lost; pend then drops so
  // the stale repeat read during the freeze is never taken.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      // Per-lane read-data capture register
      always_ff @(posedge clk) begin
        if (!rst) begin
          lane_reg[gi] <= 8'h00;
        end else if (pend_reg && (pend_lane_reg == 2'(gi))) begin
          lane_reg[gi] <= mem_din;
        end
      end
      assign word[8*gi +: 8] = lane_reg[gi];
    end
  endgenerate

  mem_arb_extend u_extend (
    .word    (word),
    .size    (size_reg),
    .sign_en (sign_reg),
    .result  (ls_ext)
  );

  // Results are visible in the done cycle and held afterwards
  assign if_rdata = if_done ? word : if_rdata_reg;
  assign ls_rdata = (ls_done && !we_reg) ? ls_ext : ls_rdata_reg;

  // State and datapath registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_IF;
      addr_reg      <= 32'h0;
      size_reg      <= SZ_WORD;
      we_reg        <= 1'b0;
      sign_reg      <= 1'b0;
      wdata_reg     <= 32'h0;
      cnt_reg       <= 3'd0;
      starve_reg    <= 3'd0;
      io_full_reg   <= 1'b0;
      pend_reg      <= 1'b0;
      pend_lane_reg <= 2'd0;
      if_rdata_reg  <= 32'h0;
      ls_rdata_reg  <= 32'h0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      addr_reg      <= addr_next;
      size_reg      <= size_next;
      we_reg        <= we_next;
      sign_reg      <= sign_next;
      wdata_reg     <= wdata_next;
      cnt_reg       <= cnt_next;
      starve_reg    <= starve_next;
      io_full_reg   <= io_buffer_full;
      pend_reg      <= pend_next;
      pend_lane_reg <= pend_lane_next;
      if_rdata_reg  <= if_rdata_next;
      ls_rdata_reg  <= ls_rdata_next;
    end
  end

  // Next-state, grant, beat sequencing and RAM-side outputs
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    addr_next      = addr_reg;
    size_next      = size_reg;
    we_next        = we_reg;
    sign_next      = sign_reg;
    wdata_next     = wdata_reg;
    cnt_next       = cnt_reg;
    starve_next    = starve_reg;
    pend_next      = 1'b0;
    pend_lane_next = pend_lane_reg;
    if_rdata_next  = if_rdata_reg;
    ls_rdata_next  = ls_rdata_reg;
    if_done        = 1'b0;
    ls_done        = 1'b0;
    mem_wr         = 1'b0;
    mem_a          = 32'h0;
    mem_dout       = 8'h00;

    if (rdy && clear) begin
      starve_next = 3'd0;
    end

    case (state_reg)
      IDLE: begin
        // A flush cycle never starts a new access
        if (rdy && !clear && (if_req || ls_req)) begin
          cnt_next = 3'd0;
          if (grant_ls) begin
            owner_next = OWN_LS;
            addr_next  = ls_addr;
            size_next  = ls_size;
            we_next    = ls_we;
            sign_next  = ls_signed;
            wdata_next = ls_wdata;
            if (if_req && (starve_reg != STARVE_LIM)) begin
              starve_next = starve_reg + 3'd1;
            end
            state_next = ls_we ? WR : RD;
          end else begin
            owner_next  = OWN_IF;
            addr_next   = if_addr;
            size_next   = SZ_WORD;
            we_next     = 1'b0;
            sign_next   = 1'b0;
            wdata_next  = 32'h0;
            starve_next = 3'd0;
            state_next  = RD;
          end
        end
      end

      RD: begin
        mem_a = cur_addr;
        if (rdy) begin
          if (clear) begin
            state_next = IDLE;
            cnt_next   = 3'd0;
          end else begin
            pend_next      = 1'b1;
            pend_lane_next = cnt_reg[1:0];
            if (last_beat) begin
              state_next = RD_TAIL;
              cnt_next   = 3'd0;
            end else begin
              cnt_next = cnt_reg + 3'd1;
            end
          end
        end
      end

      RD_TAIL: begin
        if (rdy) begin
          state_next = clear ? IDLE : DONE;
        end
      end

      WR: begin
        mem_a    = cur_addr;
        mem_dout = wdata_reg[{cnt_reg[1:0], 3'b000} +: 8];
        mem_wr   = rdy && !io_hold;
        if (rdy && !io_hold) begin
          if (last_beat) begin
            state_next = DONE;
            cnt_next   = 3'd0;
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
      end

      DONE: begin
        if (rdy) begin
          state_next = IDLE;
          // A flush discards a finished read but never a committed store
          if (!(clear && !we_reg)) begin
            if (owner_reg == OWN_LS) begin
              ls_done = 1'b1;
              if (!we_reg) begin
                ls_rdata_next = ls_ext;
              end
            end else begin
              if_done       = 1'b1;
              if_rdata_next = word;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte RAM model with one-cycle read
// latency, transaction helper with per-cycle logging, immediate-assertion
// checks against hand-computed values.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we, ls_signed;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;

  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  ram [0:65535];

  logic        mw_log [0:20];
  logic [31:0] ma_log [0:20];
  logic [7:0]  md_log [0:20];

  int total = 0;
  int bad   = 0;
  int lat, nw, n, ndone, first_wr;
  logic [5:0] ord;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_wr(mem_wr), .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din)
  );

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    mem_din <= ram[mem_a[15:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  // Issue one request in the current (grant) cycle and run until its done.
  // ca: clear cycle, rf/rl: rdy-low window, fu: io_buffer_full high for c < fu.
  task automatic xact(input bit is_ls, input bit we, input logic [1:0] sz, input bit sg,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int ca, input int rf, input int rl, input int fu,
                      output int lat_o, output int nw_o);
    for (int i = 0; i <= 20; i++) begin
      mw_log[i] = 1'b0; ma_log[i] = 32'h0; md_log[i] = 8'h00;
    end
    lat_o = -1;
    nw_o  = 0;
    if (is_ls) begin
      ls_we = we; ls_size = sz; ls_signed = sg; ls_addr = addr; ls_wdata = wd; ls_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    io_buffer_full = (0 < fu);
    for (int c = 1; c <= 20; c++) begin
      tick();
      rdy = !(c >= rf && c < rf + rl);
      clear = (c == ca);
      io_buffer_full = (c < fu);
      if (clear && !we) begin
        if_req = 1'b0; ls_req = 1'b0;
      end
      #1;
      mw_log[c] = mem_wr; ma_log[c] = mem_a; md_log[c] = mem_dout;
      if (mem_wr) nw_o++;
      if (is_ls ? ls_done : if_done) begin
        lat_o = c;
        break;
      end
    end
    if_req = 1'b0; ls_req = 1'b0; clear = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    tick();
    $display("xact ls=%0d we=%0d size=%0d addr=%h latency=%0d writes=%0d if_rdata=%h ls_rdata=%h",
             is_ls, we, sz, addr, lat_o, nw_o, if_rdata, ls_rdata);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_signed = 1'b0;
    ls_addr = 32'h0; ls_wdata = 32'h0;
    pre_we = 1'b0; pre_addr = 16'h0; pre_data = 8'h0;
    #1;
    // Preload RAM while in reset
    poke(16'h0100, 8'h11); poke(16'h0101, 8'h22);
    poke(16'h0102, 8'h33); poke(16'h0103, 8'h44);
    poke(16'h0200, 8'h80);
    poke(16'h0202, 8'h34); poke(16'h0203, 8'hA5);
    rst = 1'b1;
    #1;
    check("rst_if_done", 32'(if_done), 32'h0);
    check("rst_ls_done", 32'(ls_done), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);

    // Instruction fetch of a word
    xact(0, 0, 2'd2, 0, 32'h100, 32'h0, -1, -1, 0, 0, lat, nw);
    check("fetch_lat", 32'(lat), 32'd6);
    check("fetch_data", if_rdata, 32'h4433_2211);
    check("fetch_a1", ma_log[1], 32'h100);
    check("fetch_a4", ma_log[4], 32'h103);

    // Byte and half loads, signed and unsigned
    xact(1, 0, 2'd0, 1, 32'h200, 32'h0, -1, -1, 0, 0, lat, nw);
    check("lb_lat", 32'(lat), 32'd3);
    check("lb_signed", ls_rdata, 32'hFFFF_FF80);
    xact(1, 0, 2'd0, 0, 32'h200, 32'h0, -1, -1, 0, 0, lat, nw);
    check("lbu", ls_rdata, 32'h0000_0080);
    xact(1, 0, 2'd1, 1, 32'h202, 32'h0, -1, -1, 0, 0, lat, nw);
    check("lh_lat", 32'(lat), 32'd4);
    check("lh_signed", ls_rdata, 32'hFFFF_A534);
    xact(1, 0, 2'd1, 0, 32'h202, 32'h0, -1, -1, 0, 0, lat, nw);
    check("lhu", ls_rdata, 32'h0000_A534);
    check("if_rdata_hold", if_rdata, 32'h4433_2211);

    // Word store and read back
    xact(1, 1, 2'd2, 0, 32'h300, 32'hDEAD_BEEF, -1, -1, 0, 0, lat, nw);
    check("sw_lat", 32'(lat), 32'd5);
    check("sw_writes", 32'(nw), 32'd4);
    check("sw_dout1", 32'(md_log[1]), 32'hEF);
    check("sw_dout4", 32'(md_log[4]), 32'hDE);
    xact(1, 0, 2'd2, 0, 32'h300, 32'h0, -1, -1, 0, 0, lat, nw);
    check("sw_readback", ls_rdata, 32'hDEAD_BEEF);

    // IO store held while the buffer is full (cycles 0..4)
    xact(1, 1, 2'd0, 0, 32'h0003_0000, 32'h0000_0041, -1, -1, 0, 5, lat, nw);
    first_wr = 0;
    for (int c = 20; c >= 1; c--) if (mw_log[c]) first_wr = c;
    check("io_first_wr", 32'(first_wr), 32'd6);
    check("io_dout", 32'(md_log[6]), 32'h41);
    check("io_writes", 32'(nw), 32'd1);
    check("io_lat", 32'(lat), 32'd7);

    // Both requesters held: four LSU grants then one fetch
    ls_we = 1'b0; ls_size = 2'd0; ls_signed = 1'b0; ls_addr = 32'h200;
    if_addr = 32'h100; if_req = 1'b1; ls_req = 1'b1;
    ord = 6'b0; n = 0;
    for (int c = 0; c < 300 && n < 6; c++) begin
      tick(); #1;
      if (ls_done) begin ord = {ord[4:0], 1'b1}; n++; end
      else if (if_done) begin ord = {ord[4:0], 1'b0}; n++; end
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick();
    $display("starve grants=%0d order=%b", n, ord);
    check("starve_count", 32'(n), 32'd6);
    check("starve_order", 32'(ord), 32'b111101);

    // Flush during fetch read cycle 3: aborted, idle next cycle
    xact(0, 0, 2'd2, 0, 32'h100, 32'h0, 3, -1, 0, 0, lat, nw);
    check("clr_rd_nodone", 32'(lat), 32'hFFFF_FFFF);
    check("clr_rd_a3", ma_log[3], 32'h102);
    check("clr_rd_idle", ma_log[4], 32'h0);

    // Flush during store cycle 2: store completes
    xact(1, 1, 2'd2, 0, 32'h400, 32'hCAFE_F00D, 2, -1, 0, 0, lat, nw);
    check("clr_wr_lat", 32'(lat), 32'd5);
    check("clr_wr_writes", 32'(nw), 32'd4);
    xact(1, 0, 2'd2, 0, 32'h400, 32'h0, -1, -1, 0, 0, lat, nw);
    check("clr_wr_readback", ls_rdata, 32'hCAFE_F00D);

    // rdy low for 3 cycles mid-read
    xact(1, 0, 2'd2, 0, 32'h100, 32'h0, -1, 2, 3, 0, lat, nw);
    check("rdy_rd_lat", 32'(lat), 32'd9);
    check("rdy_rd_data", ls_rdata, 32'h4433_2211);

    // rdy low for 2 cycles mid-store: no write strobes while frozen
    xact(1, 1, 2'd2, 0, 32'h500, 32'h1122_3344, -1, 2, 2, 0, lat, nw);
    check("rdy_wr_lat", 32'(lat), 32'd7);
    check("rdy_wr_mw2", 32'(mw_log[2]), 32'h0);
    check("rdy_wr_mw3", 32'(mw_log[3]), 32'h0);
    check("rdy_wr_writes", 32'(nw), 32'd4);

    // Reset in the middle of a store
    ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h600; ls_wdata = 32'h5566_7788; ls_req = 1'b1;
    tick(); tick();
    check("mid_wr_active", 32'(mem_wr), 32'h1);
    rst = 1'b0;
    tick(); #1;
    check("rstw_mem_wr", 32'(mem_wr), 32'h0);
    check("rstw_mem_a", mem_a, 32'h0);
    check("rstw_mem_dout", 32'(mem_dout), 32'h0);
    check("rstw_ls_done", 32'(ls_done), 32'h0);
    check("rstw_ls_rdata", ls_rdata, 32'h0);
    check("rstw_if_rdata", if_rdata, 32'h0);
    ls_req = 1'b0;
    rst = 1'b1;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      tick(); #1;
      if (ls_done || if_done) ndone++;
    end
    $display("post-reset done pulses=%0d", ndone);
    check("rstw_no_done", 32'(ndone), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
